// File: rtl/uart_board_rx.sv
// rtl/uart_board_rx.sv - 8N1 receiver assembling sync-framed board vectors; checksum byte enabled by UART_BOARD_RX_CHECKSUM_EN
module uart_board_rx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         N_TILES      = 16,
    parameter int         TILE_W       = 12,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_rx,
    output logic [N_TILES*TILE_W-1:0]   o_board,
    output logic                        o_board_valid,
    output logic                        o_frame_err,
    output logic                        o_busy
);
    localparam int BOARD_W      = N_TILES * TILE_W;
    localparam int NB           = BOARD_W / 8;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int GAP_W        = $clog2(TIMEOUT_CLKS + 1);
    localparam int BCNT_W       = $clog2(NB + 1);
`ifdef UART_BOARD_RX_CHECKSUM_EN
    localparam int SHR_W        = BOARD_W;
`else
    // Last payload byte is committed straight from the receiver, so one byte less is held here.
    localparam int SHR_W        = BOARD_W - 8;
`endif

    if ((N_TILES * TILE_W) % 8 != 0) begin : g_nb_check
        $error("uart_board_rx: N_TILES*TILE_W must be a multiple of 8");
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {
        FR_HUNT,
        FR_PAYLOAD
`ifdef UART_BOARD_RX_CHECKSUM_EN
        , FR_CHECK
`endif
    } fr_state_t;

    logic               rx_s1, rx_s2, rx_d, rx_fall;
    rx_state_t          rx_state, rx_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         rx_shift, rx_byte;
    logic               half_tick, full_tick, sample_bit, stop_ok, stop_bad, cnt_clear;
    logic               rx_strobe, rx_ferr;

    fr_state_t          fr_state, fr_nxt;
    logic [SHR_W-1:0]   shreg;
    logic [BCNT_W-1:0]  byte_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               last_byte, gap_expired;
    logic               do_clear, do_shift, do_commit, do_err;
`ifdef UART_BOARD_RX_CHECKSUM_EN
    logic [7:0]         xor_acc;
`endif

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= i_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall   = rx_d & ~rx_s2;
    assign half_tick = (bit_cnt == CNT_W'(HALF_BIT - 1));
    assign full_tick = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Bit receiver state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_nxt;
    end

    // Bit receiver next state
    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_nxt = RX_START;
            RX_START: if (half_tick) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && bit_idx == 3'd7) rx_nxt = RX_STOP;
            RX_STOP:  if (full_tick) rx_nxt = RX_IDLE;
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    // Bit receiver sample and strobe decodes
    always_comb begin
        sample_bit = (rx_state == RX_DATA) && full_tick;
        stop_ok    = (rx_state == RX_STOP) && full_tick && rx_s2;
        stop_bad   = (rx_state == RX_STOP) && full_tick && !rx_s2;
        cnt_clear  = (rx_state != rx_nxt) || sample_bit;
    end

    // Bit timing counter, data shifter and registered byte strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            rx_shift  <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_strobe <= stop_ok;
            rx_ferr   <= stop_bad;
            if (cnt_clear)                bit_cnt <= '0;
            else if (rx_state != RX_IDLE) bit_cnt <= bit_cnt + CNT_W'(1);
            if (rx_state == RX_START)     bit_idx <= '0;
            else if (sample_bit)          bit_idx <= bit_idx + 3'd1;
            if (sample_bit)               rx_shift <= {rx_s2, rx_shift[7:1]};
            if (stop_ok)                  rx_byte <= rx_shift;
        end
    end

    assign last_byte   = (byte_cnt == BCNT_W'(NB - 1));
    assign gap_expired = (gap_cnt == GAP_W'(TIMEOUT_CLKS - 1));

    // Frame assembler state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fr_state <= FR_HUNT;
        else      fr_state <= fr_nxt;
    end

    // Frame assembler next state; a strobe always beats a simultaneous timeout
    always_comb begin
        fr_nxt = fr_state;
        case (fr_state)
            FR_HUNT: if (rx_strobe && rx_byte == SYNC_BYTE) fr_nxt = FR_PAYLOAD;
            FR_PAYLOAD: begin
                if (rx_ferr) fr_nxt = FR_HUNT;
                else if (rx_strobe) begin
`ifdef UART_BOARD_RX_CHECKSUM_EN
                    if (last_byte) fr_nxt = FR_CHECK;
`else
                    if (last_byte) fr_nxt = FR_HUNT;
`endif
                end else if (gap_expired) fr_nxt = FR_HUNT;
            end
`ifdef UART_BOARD_RX_CHECKSUM_EN
            FR_CHECK: if (rx_ferr || rx_strobe || gap_expired) fr_nxt = FR_HUNT;
`endif
            default: fr_nxt = FR_HUNT;
        endcase
    end

    // Frame assembler actions: clear on sync, shift payload, commit or flag an error
    always_comb begin
        do_clear  = 1'b0;
        do_shift  = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;
        o_busy    = (fr_state != FR_HUNT);
        case (fr_state)
            FR_HUNT: do_clear = rx_strobe && (rx_byte == SYNC_BYTE);
            FR_PAYLOAD: begin
                do_shift = rx_strobe;
`ifndef UART_BOARD_RX_CHECKSUM_EN
                do_commit = rx_strobe && last_byte;
`endif
                do_err   = rx_ferr || (!rx_strobe && gap_expired);
            end
`ifdef UART_BOARD_RX_CHECKSUM_EN
            FR_CHECK: begin
                do_commit = rx_strobe && (rx_byte == xor_acc);
                do_err    = rx_ferr || (rx_strobe && (rx_byte != xor_acc)) || (!rx_strobe && gap_expired);
            end
`endif
            default: ;
        endcase
    end

    // Payload shift register, gap timer and the committed board outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg         <= '0;
            byte_cnt      <= '0;
            gap_cnt       <= '0;
            o_board       <= '0;
            o_board_valid <= 1'b0;
            o_frame_err   <= 1'b0;
`ifdef UART_BOARD_RX_CHECKSUM_EN
            xor_acc       <= '0;
`endif
        end else begin
            o_board_valid <= do_commit;
            o_frame_err   <= do_err;
            if (do_clear) begin
                shreg    <= '0;
                byte_cnt <= '0;
`ifdef UART_BOARD_RX_CHECKSUM_EN
                xor_acc  <= '0;
`endif
            end else if (do_shift) begin
                shreg    <= {shreg[SHR_W-9:0], rx_byte};
                byte_cnt <= byte_cnt + BCNT_W'(1);
`ifdef UART_BOARD_RX_CHECKSUM_EN
                xor_acc  <= xor_acc ^ rx_byte;
`endif
            end
            if (rx_strobe || fr_state == FR_HUNT) gap_cnt <= '0;
            else                                  gap_cnt <= gap_cnt + GAP_W'(1);
            if (do_commit) begin
`ifdef UART_BOARD_RX_CHECKSUM_EN
                o_board <= shreg;
`else
                o_board <= {shreg, rx_byte};
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_board_rx.sv
// tb/tb_uart_board_rx.sv - self-checking bench for uart_board_rx
module tb_uart_board_rx;
    localparam int CPB     = 8;
    localparam int NT      = 16;
    localparam int TW      = 12;
    localparam int BW      = NT * TW;
    localparam int NB      = BW / 8;
    localparam int TO_BITS = 20;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int LAT_MIN = (19 * CPB) / 2 + 2;
    localparam int LAT_MAX = LAT_MIN + 4;
    localparam logic [BW-1:0] NOMINAL = {144'd0, 12'd256, 36'd0};
`ifdef UART_BOARD_RX_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [BW-1:0] board;
        logic [7:0]    ck_xor;
        int            bad_stop;
        int            exp_valid;
        int            exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic [BW-1:0] board;
    logic          board_valid, frame_err, busy;

    int total = 0;
    int bad   = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = 0;
    int last_start_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;
    logic [BW-1:0] last_good = '0;

    uart_board_rx #(
        .CLKS_PER_BIT(CPB), .N_TILES(NT), .TILE_W(TW),
        .SYNC_BYTE(SYNC), .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk(clk), .rst(rst), .i_rx(rx), .o_board(board),
        .o_board_valid(board_valid), .o_frame_err(frame_err), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts pulses, checks width and that busy is already low
    always @(negedge clk) begin
        if (board_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            check_int("valid_pulse_width", int'(prev_valid), 0);
            check_int("busy_low_at_valid", int'(busy), 0);
        end
        if (frame_err) begin
            err_cnt++;
            check_int("err_pulse_width", int'(prev_err), 0);
            check_int("busy_low_at_err", int'(busy), 0);
        end
        prev_valid = board_valid;
        prev_err   = frame_err;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        rx = 1'b0;
        last_start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_q(input byte_q_t q, input int bad_stop, input int gap);
        foreach (q[i]) send_byte(q[i], (i != bad_stop), gap);
    endtask

    function automatic byte_q_t make_frame(input logic [BW-1:0] brd, input logic [7:0] ck_xor);
        byte_q_t q;
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        q.push_back(SYNC);
        for (int k = 0; k < NB; k++) begin
            b = brd[BW-1-8*k -: 8];
            q.push_back(b);
            x ^= b;
        end
        if (CK_EN) q.push_back(x ^ ck_xor);
        return q;
    endfunction

    // Reference: locate the first sync, take NB bytes, verify XOR if a checksum follows
    task automatic model_frame(input byte_q_t q, output int commit, output int err, output logic [BW-1:0] brd);
        int s = -1;
        logic [7:0] x = 8'h00;
        brd = '0;
        for (int i = 0; i < q.size(); i++) if (s < 0 && q[i] == SYNC) s = i;
        for (int k = 0; k < NB; k++) begin
            brd = {brd[BW-9:0], q[s+1+k]};
            x ^= q[s+1+k];
        end
        commit = 1;
        if (CK_EN && q[s+NB+1] != x) commit = 0;
        err = 1 - commit;
    endtask

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] r = '0;
        for (int i = 0; i < BW / 32; i++) r = {r[BW-33:0], 32'($urandom())};
        return r;
    endfunction

    initial begin
        vec_t vecs[5];
        byte_q_t q, q2;
        logic [BW-1:0] b1, b2, eb;
        logic [7:0] j;
        int v0, e0, lat, ecommit, eerr, njunk, gap;

        vecs[0] = '{board: NOMINAL, ck_xor: 8'h00, bad_stop: -1, exp_valid: 1, exp_err: 0};
        vecs[1] = '{board: NOMINAL, ck_xor: 8'h01, bad_stop: -1,
                    exp_valid: CK_EN ? 0 : 1, exp_err: CK_EN ? 1 : 0};
        vecs[2] = '{board: 192'hA5A5_0011_2233_4455_6677_8899_AABB_CCDD_EEFF_A500_0102_0304,
                    ck_xor: 8'h00, bad_stop: -1, exp_valid: 1, exp_err: 0};
        vecs[3] = '{board: 192'h1, ck_xor: 8'h00, bad_stop: 5, exp_valid: 0, exp_err: 1};
        vecs[4] = '{board: {BW{1'b1}}, ck_xor: 8'h00, bad_stop: -1, exp_valid: 1, exp_err: 0};

        repeat (5) @(negedge clk);
        check_vec("reset_board", board, '0);
        check_int("reset_valid", int'(board_valid), 0);
        check_int("reset_err", int'(frame_err), 0);
        check_int("reset_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_q(make_frame(vecs[i].board, vecs[i].ck_xor), vecs[i].bad_stop, 0);
            repeat (2 * CPB) @(negedge clk);
            if (vecs[i].exp_valid != 0) last_good = vecs[i].board;
            check_int($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
            check_int($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            check_vec($sformatf("vec%0d_board", i), board, last_good);
            if (vecs[i].exp_valid != 0) begin
                lat = last_valid_cyc - last_start_cyc;
                check_int($sformatf("vec%0d_latency_in_window", i), int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
            end
        end

        // Short glitch on idle line
        v0 = valid_cnt; e0 = err_cnt;
        rx = 1'b0;
        repeat (CPB * 3 / 10) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_int("glitch_valid", valid_cnt - v0, 0);
        check_int("glitch_err", err_cnt - e0, 0);
        check_int("glitch_busy", int'(busy), 0);

        // Leading noise bytes before sync
        b1 = rand_board();
        q = {8'h00, 8'hFF};
        q2 = make_frame(b1, 8'h00);
        foreach (q2[i]) q.push_back(q2[i]);
        v0 = valid_cnt; e0 = err_cnt;
        send_q(q, -1, 0);
        repeat (2 * CPB) @(negedge clk);
        last_good = b1;
        check_int("noise_valid", valid_cnt - v0, 1);
        check_int("noise_err", err_cnt - e0, 0);
        check_vec("noise_board", board, last_good);

        // Two frames with no idle gap between them
        b1 = rand_board();
        b2 = rand_board();
        q = make_frame(b1, 8'h00);
        q2 = make_frame(b2, 8'h00);
        foreach (q2[i]) q.push_back(q2[i]);
        v0 = valid_cnt; e0 = err_cnt;
        send_q(q, -1, 0);
        repeat (2 * CPB) @(negedge clk);
        last_good = b2;
        check_int("b2b_valid", valid_cnt - v0, 2);
        check_int("b2b_err", err_cnt - e0, 0);
        check_vec("b2b_board", board, last_good);

        // Stall after sync plus 10 payload bytes
        q = make_frame(rand_board(), 8'h00);
        v0 = valid_cnt; e0 = err_cnt;
        for (int i = 0; i < 11; i++) send_byte(q[i], 1'b1, 0);
        repeat (CPB) @(negedge clk);
        check_int("stall_busy_before", int'(busy), 1);
        repeat ((TO_BITS - 3) * CPB) @(negedge clk);
        check_int("stall_no_early_err", err_cnt - e0, 0);
        repeat (3 * CPB) @(negedge clk);
        check_int("stall_err", err_cnt - e0, 1);
        check_int("stall_busy_after", int'(busy), 0);
        check_int("stall_valid", valid_cnt - v0, 0);
        b1 = rand_board();
        v0 = valid_cnt;
        send_q(make_frame(b1, 8'h00), -1, 0);
        repeat (2 * CPB) @(negedge clk);
        last_good = b1;
        check_int("stall_recover_valid", valid_cnt - v0, 1);
        check_vec("stall_recover_board", board, last_good);

        // Reset asserted in the middle of byte 12
        q = make_frame(rand_board(), 8'h00);
        for (int i = 0; i < 12; i++) send_byte(q[i], 1'b1, 0);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        last_good = '0;
        check_vec("midrst_board", board, last_good);
        check_int("midrst_valid", int'(board_valid), 0);
        check_int("midrst_err", int'(frame_err), 0);
        check_int("midrst_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        b1 = rand_board();
        v0 = valid_cnt; e0 = err_cnt;
        send_q(make_frame(b1, 8'h00), -1, 0);
        repeat (2 * CPB) @(negedge clk);
        last_good = b1;
        check_int("midrst_next_valid", valid_cnt - v0, 1);
        check_int("midrst_next_err", err_cnt - e0, 0);
        check_vec("midrst_next_board", board, last_good);

        // Randomized frames: junk prefix, random gaps, occasional corrupt checksum
        for (int r = 0; r < 6; r++) begin
            q = '{};
            njunk = $urandom_range(0, 2);
            for (int k = 0; k < njunk; k++) begin
                do j = 8'($urandom()); while (j == SYNC);
                q.push_back(j);
            end
            j = (CK_EN && $urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            q2 = make_frame(rand_board(), j);
            foreach (q2[i]) q.push_back(q2[i]);
            gap = $urandom_range(0, 2 * CPB);
            model_frame(q, ecommit, eerr, eb);
            v0 = valid_cnt; e0 = err_cnt;
            send_q(q, -1, gap);
            repeat (2 * CPB) @(negedge clk);
            if (ecommit != 0) last_good = eb;
            check_int($sformatf("rand%0d_valid", r), valid_cnt - v0, ecommit);
            check_int($sformatf("rand%0d_err", r), err_cnt - e0, eerr);
            check_vec($sformatf("rand%0d_board", r), board, last_good);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
